fetch_queue: RTL

- Parametrised successor to the single-instruction fetch unit: a prefetching instruction fetch engine with a DEPTH-entry instruction queue.
- Issues sequential reads to synchronous program memory, buffers returned instructions with their PC, and presents them to decode over a valid/ready handshake.
- Adds redirect (branch/loop jump) with queue flush, an enable/stall control, and generalised address and data widths.
- Sits between program memory and the CPU decode/execute logic.

---
 rtl/fetch_queue_if.sv | 31 +++
 rtl/fetch_queue.sv | 96 +++++++++
 2 files changed

// File: rtl/fetch_queue_if.sv
// Fetch queue bus: program-memory read port plus the decode-side handshake.
// master is the fetch engine, slave is the surrounding memory/decode logic.
interface fetch_queue_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              fetch_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_data;
  logic              inst_valid;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [CNT_W-1:0]  queue_count;

  modport master (
    input  fetch_en, mem_data, inst_ready, redirect, redirect_pc,
    output mem_addr, mem_rd_en, inst_valid, inst_data, inst_pc, queue_count
  );

  modport slave (
    output fetch_en, mem_data, inst_ready, redirect, redirect_pc,
    input  mem_addr, mem_rd_en, inst_valid, inst_data, inst_pc, queue_count
  );
endinterface

// File: rtl/fetch_queue.sv
// Prefetching instruction fetch engine. Issues sequential reads to a 1-cycle
// synchronous program memory, buffers returned words with their PC in a
// DEPTH-entry FIFO and hands them to decode over valid/ready. A redirect
// flushes the queue and drops the in-flight response.
module fetch_queue #(
  parameter int unsigned          ADDR_W   = 8,
  parameter int unsigned          DATA_W   = 8,
  parameter int unsigned          DEPTH    = 4,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("fetch_queue: DEPTH must be a power of two, at least 2");
  end

  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] req_pc_q;
  logic              inflight_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];

  logic [CNT_W-1:0]  occupancy;
  logic              valid;
  logic              issue;
  logic              push;
  logic              pop;

  // Issue credit counts queued plus in-flight entries and deliberately ignores
  // a same-cycle pop, so a push can never find the queue full.
  always_comb begin
    occupancy = count_q + CNT_W'(inflight_q);
    valid     = (count_q != '0);
    issue     = bus.fetch_en & ~rst & ~bus.redirect & (occupancy < CNT_W'(DEPTH));
    push      = inflight_q & ~bus.redirect & ~rst;
    pop       = valid & bus.inst_ready & ~bus.redirect & ~rst;
  end

  assign bus.mem_rd_en   = issue;
  assign bus.mem_addr    = fetch_pc_q;
  assign bus.inst_valid  = valid;
  assign bus.inst_data   = valid ? data_q[rd_ptr_q] : '0;
  assign bus.inst_pc     = valid ? pc_q[rd_ptr_q] : '0;
  assign bus.queue_count = count_q;

  // Fetch PC, in-flight tracking and queue pointers; reset beats redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else if (bus.redirect) begin
      fetch_pc_q <= bus.redirect_pc;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      if (issue) begin
        fetch_pc_q <= fetch_pc_q + ADDR_W'(1);
        req_pc_q   <= fetch_pc_q;
      end
      inflight_q <= issue;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Queue storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= bus.mem_data;
      pc_q[wr_ptr_q]   <= req_pc_q;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && count_q == CNT_W'(DEPTH)));

endmodule
